// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared types and constants for branch resolution
package branch_resolver_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_COND, REDIRECT} state_e;
    typedef enum logic [1:0] {
        EXC_NONE           = 2'd0,
        EXC_ILLEGAL_BRANCH = 2'd1,
        EXC_MISALIGNED     = 2'd2
    } exc_cause_e;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: taken target, fallthrough and target alignment for a PC-relative branch
module branch_target_calc
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [ADDR_WIDTH-1:0] target_o,
    output logic [ADDR_WIDTH-1:0] fallthrough_o,
    output logic                  misaligned_o
);
    assign target_o      = pc_i + imm_i[ADDR_WIDTH-1:0];
    assign fallthrough_o = pc_i + ADDR_WIDTH'(INSTR_BYTES);
    assign misaligned_o  = |target_o[1:0];
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves one conditional branch at a time from the comparator verdict,
// raising redirect, predictor-update and exception outputs.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_pc,
    input  logic [DATA_WIDTH-1:0] issue_imm,
    input  logic                  issue_pred_taken,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    input  logic                  cond_taken,
    input  logic                  cond_legal,
    input  logic                  cond_valid,
    input  logic                  flush,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [TAG_WIDTH-1:0]  redirect_tag,
    output logic                  resolve_valid,
    output logic                  resolve_taken,
    output logic                  resolve_mispredict,
    output logic                  exc_valid,
    output logic [1:0]            exc_cause,
    output logic [TAG_WIDTH-1:0]  exc_tag
);
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  pred_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  redirect_valid_q, resolve_valid_q, resolve_taken_q, resolve_mispredict_q, exc_valid_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic [TAG_WIDTH-1:0]  redirect_tag_q, exc_tag_q;
    exc_cause_e            exc_cause_q;

    logic                  in_idle, resolving, mispredict, misaligned, cur_pred;
    logic [ADDR_WIDTH-1:0] cur_pc, target, fallthrough;
    logic [DATA_WIDTH-1:0] cur_imm;
    logic [TAG_WIDTH-1:0]  cur_tag;

    // In IDLE a same-cycle verdict resolves straight from the issue bus
    assign in_idle    = state_q == IDLE;
    assign cur_pc     = in_idle ? issue_pc : pc_q;
    assign cur_imm    = in_idle ? issue_imm : imm_q;
    assign cur_pred   = in_idle ? issue_pred_taken : pred_q;
    assign cur_tag    = in_idle ? issue_tag : tag_q;
    assign resolving  = cond_valid && ((in_idle && issue_valid) || state_q == WAIT_COND);
    assign mispredict = cond_taken ^ cur_pred;

    branch_target_calc #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_calc (
        .pc_i         (cur_pc),
        .imm_i        (cur_imm),
        .target_o     (target),
        .fallthrough_o(fallthrough),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            pc_q                 <= '0;
            imm_q                <= '0;
            pred_q               <= 1'b0;
            tag_q                <= '0;
            redirect_valid_q     <= 1'b0;
            redirect_pc_q        <= '0;
            redirect_tag_q       <= '0;
            resolve_valid_q      <= 1'b0;
            resolve_taken_q      <= 1'b0;
            resolve_mispredict_q <= 1'b0;
            exc_valid_q          <= 1'b0;
            exc_cause_q          <= EXC_NONE;
            exc_tag_q            <= '0;
        end else begin
            resolve_valid_q <= 1'b0;
            exc_valid_q     <= 1'b0;
            if (in_idle && issue_valid) begin
                pc_q   <= issue_pc;
                imm_q  <= issue_imm;
                pred_q <= issue_pred_taken;
                tag_q  <= issue_tag;
            end
            if (flush) begin
                state_q          <= IDLE;
                redirect_valid_q <= 1'b0;
            end else if (resolving) begin
                state_q <= IDLE;
                if (!cond_legal || (cond_taken && misaligned)) begin
                    exc_valid_q <= 1'b1;
                    exc_cause_q <= cond_legal ? EXC_MISALIGNED : EXC_ILLEGAL_BRANCH;
                    exc_tag_q   <= cur_tag;
                end else begin
                    resolve_valid_q      <= 1'b1;
                    resolve_taken_q      <= cond_taken;
                    resolve_mispredict_q <= mispredict;
                    if (mispredict) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= cond_taken ? target : fallthrough;
                        redirect_tag_q   <= cur_tag;
                    end
                end
            end else if (in_idle && issue_valid) begin
                state_q <= WAIT_COND;
            end else if (state_q == REDIRECT && redirect_ready) begin
                state_q          <= IDLE;
                redirect_valid_q <= 1'b0;
            end
        end
    end

    assign issue_ready        = in_idle;
    assign redirect_valid     = redirect_valid_q;
    assign redirect_pc        = redirect_pc_q;
    assign redirect_tag       = redirect_tag_q;
    assign resolve_valid      = resolve_valid_q;
    assign resolve_taken      = resolve_taken_q;
    assign resolve_mispredict = resolve_mispredict_q;
    assign exc_valid          = exc_valid_q;
    assign exc_cause          = exc_cause_q;
    assign exc_tag            = exc_tag_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed scenarios plus randomized branches checked against a reference model
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        rst_n, issue_valid, issue_ready, issue_pred_taken;
    logic [31:0] issue_pc, issue_imm, redirect_pc;
    logic [3:0]  issue_tag, redirect_tag, exc_tag;
    logic        cond_taken, cond_legal, cond_valid, flush;
    logic        redirect_valid, redirect_ready;
    logic        resolve_valid, resolve_taken, resolve_mispredict, exc_valid;
    logic [1:0]  exc_cause;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_pred_taken(issue_pred_taken), .issue_tag(issue_tag),
        .cond_taken(cond_taken), .cond_legal(cond_legal), .cond_valid(cond_valid), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .redirect_tag(redirect_tag),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_mispredict(resolve_mispredict),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tag(exc_tag)
    );

    typedef struct {
        logic        exc;
        logic [1:0]  cause;
        logic        res;
        logic        taken;
        logic        mp;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    // Expected outcome of one resolved branch, straight from the architectural rules
    function automatic exp_t model(logic [31:0] pc, logic [31:0] imm, logic pred, logic taken, logic legal);
        exp_t        e;
        logic [31:0] tgt;
        tgt = pc + imm;
        e = '{exc: 1'b0, cause: 2'd0, res: 1'b0, taken: 1'b0, mp: 1'b0, redir: 1'b0, rpc: 32'd0};
        if (!legal) begin
            e.exc = 1'b1; e.cause = 2'd1;
        end else if (taken && (tgt % 4 != 0)) begin
            e.exc = 1'b1; e.cause = 2'd2;
        end else begin
            e.res = 1'b1; e.taken = taken; e.mp = (taken != pred); e.redir = e.mp;
            e.rpc = taken ? tgt : pc + 32'd4;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(logic [31:0] pc, logic [31:0] imm, logic pred, logic [3:0] tag,
                               logic cv, logic taken, logic legal);
        issue_valid = 1'b1; issue_pc = pc; issue_imm = imm; issue_pred_taken = pred; issue_tag = tag;
        cond_valid = cv; cond_taken = taken; cond_legal = legal;
        tick();
        issue_valid = 1'b0; cond_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; issue_valid = 1'b0; issue_pc = '0; issue_imm = '0; issue_pred_taken = 1'b0;
        issue_tag = '0; cond_taken = 1'b0; cond_legal = 1'b1; cond_valid = 1'b0; flush = 1'b0;
        redirect_ready = 1'b0;
        tick(); tick();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        checks++; if ({redirect_valid, resolve_valid, exc_valid} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {redirect_valid, resolve_valid, exc_valid}); end
        checks++; if ({redirect_pc, redirect_tag, exc_cause, exc_tag} !== 42'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", {redirect_pc, redirect_tag, exc_cause, exc_tag}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mispredict_redirect();
        drive_issue(32'h100, 32'h20, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1);
        checks++; if ({resolve_valid, resolve_taken, resolve_mispredict} !== 3'b111) begin errors++; $display("FAIL tp1_resolve: got %b want 111", {resolve_valid, resolve_taken, resolve_mispredict}); end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || redirect_tag !== 4'd3) begin errors++; $display("FAIL tp1_redirect: got v=%b pc=%h tag=%h want v=1 pc=120 tag=3", redirect_valid, redirect_pc, redirect_tag); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || resolve_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL tp1_hold%0d: got v=%b pc=%h res=%b rdy=%b want 1 120 0 0", i, redirect_valid, redirect_pc, resolve_valid, issue_ready); end
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        checks++; if (redirect_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL tp1_accept: got v=%b rdy=%b want 0 1", redirect_valid, issue_ready); end
    endtask

    task automatic test_delayed_cond();
        drive_issue(32'h200, 32'hFFFF_FFF8, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (issue_ready !== 1'b0 || resolve_valid !== 1'b0) begin errors++; $display("FAIL tp2_wait%0d: got rdy=%b res=%b want 0 0", i, issue_ready, resolve_valid); end
            if (i == 3) begin cond_valid = 1'b1; cond_taken = 1'b1; end
            tick();
        end
        cond_valid = 1'b0;
        checks++; if ({resolve_valid, resolve_taken, resolve_mispredict, redirect_valid} !== 4'b1100) begin errors++; $display("FAIL tp2_resolve: got %b want 1100", {resolve_valid, resolve_taken, resolve_mispredict, redirect_valid}); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL tp2_ready: got %b want 1", issue_ready); end
        tick();
        checks++; if (resolve_valid !== 1'b0) begin errors++; $display("FAIL tp2_pulse: got %b want 0", resolve_valid); end
    endtask

    task automatic test_not_taken();
        drive_issue(32'h300, 32'h40, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
        checks++; if (redirect_pc !== 32'h304 || redirect_valid !== 1'b1) begin errors++; $display("FAIL tp3_redirect: got v=%b pc=%h want 1 304", redirect_valid, redirect_pc); end
        checks++; if ({resolve_valid, resolve_taken, resolve_mispredict} !== 3'b101) begin errors++; $display("FAIL tp3_resolve: got %b want 101", {resolve_valid, resolve_taken, resolve_mispredict}); end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_illegal();
        drive_issue(32'h400, 32'h10, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 2'd1 || exc_tag !== 4'd5) begin errors++; $display("FAIL tp4_exc: got v=%b cause=%0d tag=%0d want 1 1 5", exc_valid, exc_cause, exc_tag); end
        checks++; if ({resolve_valid, redirect_valid, issue_ready} !== 3'b001) begin errors++; $display("FAIL tp4_side: got %b want 001", {resolve_valid, redirect_valid, issue_ready}); end
        tick();
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL tp4_pulse: got %b want 0", exc_valid); end
    endtask

    task automatic test_misaligned_wrap();
        drive_issue(32'hFFFF_FFFC, 32'd6, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1);
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 2'd2 || exc_tag !== 4'd9) begin errors++; $display("FAIL tp5_misalign: got v=%b cause=%0d tag=%0d want 1 2 9", exc_valid, exc_cause, exc_tag); end
        checks++; if ({resolve_valid, redirect_valid} !== 2'b00) begin errors++; $display("FAIL tp5_side: got %b want 00", {resolve_valid, redirect_valid}); end
        drive_issue(32'hFFFF_FFFC, 32'd6, 1'b1, 4'd10, 1'b1, 1'b0, 1'b1);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || exc_valid !== 1'b0) begin errors++; $display("FAIL tp5_wrap: got v=%b pc=%h exc=%b want 1 0 0", redirect_valid, redirect_pc, exc_valid); end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive_issue(32'h500, 32'h8, 1'b0, 4'd1, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
        cond_valid = 1'b1; cond_taken = 1'b1;
        tick();
        cond_valid = 1'b0;
        checks++; if ({resolve_valid, exc_valid, redirect_valid} !== 3'b000) begin errors++; $display("FAIL flush_quiet: got %b want 000", {resolve_valid, exc_valid, redirect_valid}); end
        flush = 1'b1;
        drive_issue(32'h600, 32'h8, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
        flush = 1'b0;
        checks++; if ({resolve_valid, exc_valid, redirect_valid, issue_ready} !== 4'b0001) begin errors++; $display("FAIL flush_issue: got %b want 0001", {resolve_valid, exc_valid, redirect_valid, issue_ready}); end
    endtask

    task automatic test_reset_redirect();
        drive_issue(32'h700, 32'h40, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0; flush = 1'b1;
        tick();
        rst_n = 1'b1; flush = 1'b0;
        checks++; if ({redirect_valid, resolve_valid, issue_ready} !== 3'b001 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect: got v=%b res=%b rdy=%b pc=%h want 0 0 1 0", redirect_valid, resolve_valid, issue_ready, redirect_pc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc, imm, r;
            logic        pred, taken, legal;
            logic [3:0]  tag;
            int          delay;
            exp_t        e;
            r     = $urandom;
            pc    = $urandom & 32'hFFFF_FFFC;
            imm   = {{20{r[11]}}, r[11:1], 1'b0};
            pred  = r[12]; taken = r[13]; legal = (r[17:14] != 0); tag = r[21:18];
            delay = int'(r[23:22]);
            e     = model(pc, imm, pred, taken, legal);
            drive_issue(pc, imm, pred, tag, delay == 0, taken, legal);
            for (int d = 1; d <= delay; d++) begin
                checks++; if (resolve_valid !== 1'b0 || exc_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL rnd%0d_wait: got res=%b exc=%b rdy=%b want 0 0 0", n, resolve_valid, exc_valid, issue_ready); end
                cond_valid = (d == delay); cond_taken = (d == delay) ? taken : $urandom_range(0, 1);
                cond_legal = (d == delay) ? legal : $urandom_range(0, 1);
                tick();
            end
            cond_valid = 1'b0;
            checks++; if (exc_valid !== e.exc || resolve_valid !== e.res || redirect_valid !== e.redir) begin errors++; $display("FAIL rnd%0d_kind: got exc=%b res=%b red=%b want %b %b %b", n, exc_valid, resolve_valid, redirect_valid, e.exc, e.res, e.redir); end
            if (e.exc) begin
                checks++; if (exc_cause !== e.cause || exc_tag !== tag) begin errors++; $display("FAIL rnd%0d_exc: got cause=%0d tag=%0d want %0d %0d", n, exc_cause, exc_tag, e.cause, tag); end
            end
            if (e.res) begin
                checks++; if (resolve_taken !== e.taken || resolve_mispredict !== e.mp) begin errors++; $display("FAIL rnd%0d_res: got t=%b mp=%b want %b %b", n, resolve_taken, resolve_mispredict, e.taken, e.mp); end
            end
            if (e.redir) begin
                checks++; if (redirect_pc !== e.rpc || redirect_tag !== tag) begin errors++; $display("FAIL rnd%0d_rpc: got pc=%h tag=%0d want %h %0d", n, redirect_pc, redirect_tag, e.rpc, tag); end
                repeat ($urandom_range(0, 2)) tick();
                redirect_ready = 1'b1;
                tick();
                redirect_ready = 1'b0;
            end
            checks++; if (issue_ready !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got rdy=%b red=%b want 1 0", n, issue_ready, redirect_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_mispredict_redirect();
        test_delayed_cond();
        test_not_taken();
        test_illegal();
        test_misaligned_wrap();
        test_flush();
        test_reset_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
